// File: rtl/instr_mem_fetch.sv
// Writable instruction memory with a registered, handshaked fetch port.
// Optional power-on clear of the store is enabled by defining IMEM_INIT_CLEAR_EN.
module instr_mem_fetch #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH = 256,
   parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_ready,
   input  logic              flush,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   output logic              init_busy
);

   // Handshakes: a fetch transfers on an edge where fetch_req && fetch_ready;
   // an instruction transfers to decode on an edge where instr_valid && instr_ready.
   typedef enum logic {S_INIT, S_RUN} state_t;

`ifdef IMEM_INIT_CLEAR_EN
   localparam state_t RESET_STATE = S_INIT;
`else
   localparam state_t RESET_STATE = S_RUN;
`endif

   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic [31:0]       fetch_pc_ext;
   logic [31:0]       load_addr_ext;
   logic              fetch_in_range;
   logic              load_in_range;
   logic              fetch_accept;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign fetch_pc_ext   = 32'(fetch_pc);
   assign load_addr_ext  = 32'(load_addr);
   assign fetch_in_range = fetch_pc_ext < 32'(DEPTH);
   assign load_in_range  = load_addr_ext < 32'(DEPTH);

   // rst_n gates the ready so it reads 0 while reset is held in either build.
   assign fetch_ready  = rst_n && (state == S_RUN) && !load_en &&
                         (!instr_valid || instr_ready || flush);
   assign fetch_accept = fetch_req && fetch_ready;

`ifdef IMEM_INIT_CLEAR_EN
   assign init_busy = (state == S_INIT);
`else
   assign init_busy = 1'b0;
`endif

   // Single write port shared by the clear sweep and the program loader.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = load_addr;
      wr_data = load_data;
      if (state == S_INIT) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
         wr_data = NOP_WORD;
      end else if (load_en && load_in_range) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RESET_STATE;
         clr_addr    <= '0;
         instr_valid <= 1'b0;
         instr       <= NOP_WORD;
         instr_pc    <= '0;
      end else begin
         case (state)
            S_INIT: begin
               if (clr_addr == CLR_LAST) begin
                  state <= S_RUN;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            S_RUN: begin
               if (fetch_accept) begin
                  instr_valid <= 1'b1;
                  instr_pc    <= fetch_pc;
                  instr       <= fetch_in_range ? mem[fetch_pc] : NOP_WORD;
               end else if (instr_ready || flush) begin
                  instr_valid <= 1'b0;
               end
            end
            default: state <= RESET_STATE;
         endcase
      end
   end

endmodule

// File: doc/instr_mem_fetch.md
# instr_mem_fetch

Parametrised, writable instruction memory with a registered, handshaked fetch port. It replaces the fixed combinational program ROM in the processor front end. The instruction store is loaded at run time through a load port, and fetches return one instruction per cycle with one-cycle latency and consumer backpressure. The block sits between the PC/branch logic and the decode stage.

## Interface
- ADDR_W, 8, width of PC and load address
- DATA_W, 16, instruction width
- DEPTH, 256, number of instruction words; must be ≤ 2^ADDR_W
- NOP_WORD, 0, instruction returned for unloaded/out-of-range/reset contents
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active low
- load_en  in  1  write load_data to load_addr this cycle
- load_addr  in  ADDR_W  program load address
- load_data  in  DATA_W  program load word
- fetch_req  in  1  request fetch of fetch_pc
- fetch_pc  in  ADDR_W  address to fetch
- fetch_ready  out  1  block accepts a fetch this cycle
- flush  in  1  discard held instruction (branch/jump taken)
- instr_valid  out  1  instr/instr_pc hold a fetched instruction
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_ready  in  1  decode consumes instr this cycle
- init_busy  out  1  memory clear in progress

## Operation
- States: INIT (clearing), RUN.
- Reset behaviour:
  - Reset enters INIT when the clear feature is compiled in, otherwise RUN.
  - Outputs in reset: instr_valid=0, instr=NOP_WORD, instr_pc=0, fetch_ready=0, init_busy=1 (clear feature in) or 0 (clear feature out).
- INIT:
  - A clear counter writes NOP_WORD to addresses 0..DEPTH-1, one per cycle.
  - After writing address DEPTH-1, the block moves to RUN; init_busy falls on that edge.
  - load_en and fetch_req are ignored in INIT.
- RUN, ready and accept:
  - fetch_ready = RUN && !load_en && (!instr_valid || instr_ready || flush).
  - A fetch is accepted when fetch_req && fetch_ready.
- RUN, fetch result:
  - On the accepting edge, instr ← mem[fetch_pc], instr_pc ← fetch_pc, instr_valid ← 1.
  - If fetch_pc ≥ DEPTH, instr ← NOP_WORD.
- RUN, output register updates (when no fetch is accepted):
  - If instr_ready or flush is high, instr_valid ← 0.
  - Otherwise instr, instr_pc and instr_valid hold.
- Load:
  - load_en writes mem[load_addr] ← load_data on the edge; writes with load_addr ≥ DEPTH are dropped.
  - Load has priority over fetch: fetch_ready is 0 in any cycle with load_en.
  - A held instruction stays valid during loads and is not refreshed.
- Simultaneous events:
  - flush together with an accepted fetch: the new fetch wins, and instr_valid=1 with the new instruction.
  - flush alone: instr_valid clears.
  - instr_ready with instr_valid=0 has no effect.
- PC arithmetic is unsigned ADDR_W. The block does no PC increment or wrap; the PC source owns both.

## Timing
- Fetch latency: 1 cycle, from the accepting edge to instr_valid=1.
- Throughput: 1 instruction/cycle while instr_ready is held high.
- Write-then-read: a load at edge N followed by a fetch of the same address at edge N+1 returns the new data. The same-cycle case cannot occur.
- Backpressure: with instr_valid=1 and instr_ready=0, the outputs stay stable and fetch_ready=0.
- INIT duration: exactly DEPTH cycles after rst_n deasserts (a synchronous-release deassertion edge counts as cycle 0).
- Reset mid-operation:
  - Asserting rst_n low at any time forces the reset output values immediately.
  - Reset restarts INIT from address 0; memory contents are otherwise not guaranteed.

## Configuration
- IMEM_INIT_CLEAR_EN
  - Defined: INIT state present, init_busy as described, and all words read NOP_WORD until loaded.
  - Undefined: the block resets directly into RUN, init_busy is tied 0, and unloaded words are undefined (X in simulation). Loaded words behave identically in both builds.

## Test plan
- Clear after reset (macro defined, DEPTH=256): release rst_n, then fetch 8'h80 once init_busy=0 → init_busy high for exactly 256 cycles; instr=16'h0000, instr_pc=8'h80.
- Load then stream: load 0x00←16'hC801, 0x01←16'hD002, 0x02←16'hD803; fetch PCs 0, 1, 2 on consecutive cycles with instr_ready=1 → instr 16'hC801, 16'hD002, 16'hD803 on consecutive cycles, one cycle after each accept.
- Backpressure: fetch 0x01 with instr_ready=0 for 3 cycles → instr=16'hD002 held, fetch_ready=0; then instr_ready=1 → a pending fetch of 0x02 is accepted that same cycle.
- Load priority and write-then-read: load_en with 0x05←16'hE805 and fetch_req of 0x05 in the same cycle → fetch not accepted; fetch 0x05 next cycle → 16'hE805.
- Flush: instr_valid=1 (PC 0x0F) with flush=1 and a fetch of 0x80 in the same cycle → next cycle instr_pc=0x80, instr_valid=1. Flush alone → instr_valid=0.
- Out-of-range and reset mid-INIT (DEPTH=200): fetch 8'hF0 → NOP_WORD; load to 8'hF0 dropped. Pulse rst_n low at INIT count 50 → outputs return to reset values; INIT lasts 200 cycles from the release.
